// File: rtl/xpt_pkg.sv
// Shared constants and types for the T-state sequencer and its memory bus-cycle FSM.
package xpt_pkg;

    localparam int unsigned XPT_W = 5;

    localparam logic [XPT_W-1:0] XPT_M1_END = XPT_W'(3);
    localparam logic [XPT_W-1:0] XPT_MAX    = XPT_W'(31);

    typedef enum logic [1:0] {
        BUS_IDLE = 2'b00,
        BUS_RD   = 2'b01,
        BUS_WR   = 2'b10
    } bus_state_t;

    // Memory-phase strobes from the decoder bank.
    typedef struct packed {
        logic r0;
        logic r1;
        logic r2;
        logic w0;
        logic w1;
        logic w2;
    } bus_phase_t;

endpackage

// File: rtl/xpt_bus_fsm.sv
// External memory bus-cycle FSM (IDLE/RD/WR) with protocol error detection.
module xpt_bus_fsm
    import xpt_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  bus_phase_t i_phase,
    output logic       o_mem_rd,
    output logic       o_mem_wr,
    output logic       o_err_c
);

    bus_state_t r_state;
    bus_state_t w_state_nxt;
    logic       r_mem_rd;
    logic       r_mem_wr;
    logic       w_any_r;
    logic       w_any_w;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= BUS_IDLE;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mem_rd <= (w_state_nxt == BUS_RD);
            r_mem_wr <= (w_state_nxt == BUS_WR);
        end
    end

    // Any protocol violation parks the FSM in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_any_r     = i_phase.r0 | i_phase.r1 | i_phase.r2;
        w_any_w     = i_phase.w0 | i_phase.w1 | i_phase.w2;
        o_err_c     = (w_any_r & w_any_w)
                    | ((i_phase.r0 | i_phase.w0) & (r_state != BUS_IDLE))
                    | ((i_phase.r1 | i_phase.r2) & (r_state != BUS_RD))
                    | ((i_phase.w1 | i_phase.w2) & (r_state != BUS_WR));
        if (o_err_c) begin
            w_state_nxt = BUS_IDLE;
        end else begin
            case (r_state)
                BUS_IDLE: begin
                    if (i_phase.r0)      w_state_nxt = BUS_RD;
                    else if (i_phase.w0) w_state_nxt = BUS_WR;
                end
                BUS_RD:  if (i_phase.r2) w_state_nxt = BUS_IDLE;
                BUS_WR:  if (i_phase.w2) w_state_nxt = BUS_IDLE;
                default: w_state_nxt = BUS_IDLE;
            endcase
        end
    end

    assign o_mem_rd = r_mem_rd;
    assign o_mem_wr = r_mem_wr;

endmodule

// File: rtl/xpt_sequencer.sv
// T-state counter (XPT/notXPT), decoder enable, M1 flag and opcode-header pulse,
// wrapped around the memory bus-cycle FSM.
module xpt_sequencer
    import xpt_pkg::*;
(
    input  logic             CLK,
    input  logic             notRESET,
    input  logic             PR_Reset_XPT,
    input  logic             P2_Set_CM1,
    input  logic             Pa_Ophd,
    input  logic             PC_R0,
    input  logic             PC_R1,
    input  logic             PC_R2,
    input  logic             PC_W0,
    input  logic             PC_W1,
    input  logic             PC_W2,
    input  logic             MEM_WAIT,
    output logic [XPT_W-1:0] XPT,
    output logic [XPT_W-1:0] notXPT,
    output logic             DEC_ENABLE,
    output logic             CM1,
    output logic             OPHD_LOAD,
    output logic             MEM_RD,
    output logic             MEM_WR,
    output logic             SEQ_ERR
);

    logic [XPT_W-1:0] r_xpt;
    logic [XPT_W-1:0] r_notxpt;
    logic             r_dec_enable;
    logic             r_cm1;
    logic             r_ophd;
    logic             r_seq_err;

    logic [XPT_W-1:0] w_xpt_nxt;
    logic             w_stall;
    logic             w_adv;
    logic             w_ovf;
    logic             w_bus_err_c;
    bus_phase_t       w_phase;

    assign w_phase = {PC_R0, PC_R1, PC_R2, PC_W0, PC_W1, PC_W2};

    xpt_bus_fsm u_bus_fsm (
        .i_clk    (CLK),
        .i_rst_n  (notRESET),
        .i_phase  (w_phase),
        .o_mem_rd (MEM_RD),
        .o_mem_wr (MEM_WR),
        .o_err_c  (w_bus_err_c)
    );

    // Counter next value: restart > stall > saturate-with-error > increment.
    always_comb begin
        w_stall   = (PC_R1 | PC_W1) & MEM_WAIT;
        w_xpt_nxt = r_xpt;
        w_adv     = 1'b0;
        w_ovf     = 1'b0;
        if (r_dec_enable) begin
            if (PR_Reset_XPT) begin
                w_xpt_nxt = '0;
            end else if (!w_stall) begin
                if (r_xpt == XPT_MAX) begin
                    w_ovf = 1'b1;
                end else begin
                    w_xpt_nxt = r_xpt + XPT_W'(1);
                    w_adv     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            r_xpt        <= '0;
            r_notxpt     <= '1;
            r_dec_enable <= 1'b0;
            r_cm1        <= 1'b1;
            r_ophd       <= 1'b0;
            r_seq_err    <= 1'b0;
        end else begin
            r_dec_enable <= 1'b1;
            r_xpt        <= w_xpt_nxt;
            r_notxpt     <= ~w_xpt_nxt;
            r_ophd       <= Pa_Ophd & ~w_stall;
            r_seq_err    <= r_seq_err | w_ovf | w_bus_err_c;
            // A new M1 request overrides the end-of-fetch clear.
            if (P2_Set_CM1) begin
                r_cm1 <= 1'b1;
            end else if (w_adv && (r_xpt == XPT_M1_END)) begin
                r_cm1 <= 1'b0;
            end
        end
    end

    assign XPT        = r_xpt;
    assign notXPT     = r_notxpt;
    assign DEC_ENABLE = r_dec_enable;
    assign CM1        = r_cm1;
    assign OPHD_LOAD  = r_ophd;
    assign SEQ_ERR    = r_seq_err;

endmodule

// File: tb/tb_xpt_sequencer.sv
// Scoreboard bench for xpt_sequencer: stimulus pushes model predictions, a monitor pops and compares.
module tb_xpt_sequencer;

    logic       CLK = 1'b0;
    logic       notRESET;
    logic       PR_Reset_XPT, P2_Set_CM1, Pa_Ophd;
    logic       PC_R0, PC_R1, PC_R2, PC_W0, PC_W1, PC_W2, MEM_WAIT;
    logic [4:0] XPT, notXPT;
    logic       DEC_ENABLE, CM1, OPHD_LOAD, MEM_RD, MEM_WR, SEQ_ERR;

    xpt_sequencer dut (
        .CLK(CLK), .notRESET(notRESET),
        .PR_Reset_XPT(PR_Reset_XPT), .P2_Set_CM1(P2_Set_CM1), .Pa_Ophd(Pa_Ophd),
        .PC_R0(PC_R0), .PC_R1(PC_R1), .PC_R2(PC_R2),
        .PC_W0(PC_W0), .PC_W1(PC_W1), .PC_W2(PC_W2), .MEM_WAIT(MEM_WAIT),
        .XPT(XPT), .notXPT(notXPT), .DEC_ENABLE(DEC_ENABLE), .CM1(CM1),
        .OPHD_LOAD(OPHD_LOAD), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .SEQ_ERR(SEQ_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        bit prx, p2, pa, r0, r1, r2, w0, w1, w2, wt;
    } stim_t;

    // Behavioural model state: integer T-state, bus phase as 0=idle 1=read 2=write.
    int unsigned m_xpt;
    int unsigned m_bus;
    bit          m_en, m_cm1, m_ophd, m_err;

    logic [15:0] expq[$];
    int          total = 0;
    int          bad   = 0;
    int          ncyc  = 0;
    event        mon_ev;

    function automatic void model_reset();
        m_xpt = 0; m_bus = 0; m_en = 0; m_cm1 = 1; m_ophd = 0; m_err = 0;
    endfunction

    function automatic void model_step(stim_t s);
        bit          stall, any_r, any_w, proto;
        int unsigned old;
        stall = (s.r1 | s.w1) & s.wt;
        any_r = s.r0 | s.r1 | s.r2;
        any_w = s.w0 | s.w1 | s.w2;
        old   = m_xpt;
        if (m_en && !s.prx && !stall) begin
            if (m_xpt == 31) m_err = 1;
            else             m_xpt = m_xpt + 1;
        end else if (m_en && s.prx) begin
            m_xpt = 0;
        end
        if (s.p2) m_cm1 = 1;
        else if (m_en && !s.prx && !stall && old == 3) m_cm1 = 0;
        m_ophd = s.pa && !stall;
        proto = (any_r && any_w) || ((s.r0 || s.w0) && m_bus != 0)
             || ((s.r1 || s.r2) && m_bus != 1) || ((s.w1 || s.w2) && m_bus != 2);
        if (proto) begin
            m_err = 1;
            m_bus = 0;
        end else if (m_bus == 0 && s.r0) m_bus = 1;
        else if (m_bus == 0 && s.w0) m_bus = 2;
        else if (m_bus == 1 && s.r2) m_bus = 0;
        else if (m_bus == 2 && s.w2) m_bus = 0;
        m_en = 1;
    endfunction

    function automatic logic [15:0] model_vec();
        logic [4:0] x;
        x = 5'(m_xpt);
        return {x, ~x, m_en, m_cm1, m_ophd, m_bus == 1, m_bus == 2, m_err};
    endfunction

    // Monitor: compares DUT outputs with the oldest prediction after each edge or async event.
    initial begin
        logic [15:0] exp_v, act_v;
        forever begin
            @(posedge CLK or mon_ev);
            #1;
            ncyc++;
            if (expq.size() > 0) begin
                exp_v = expq.pop_front();
                act_v = {XPT, notXPT, DEC_ENABLE, CM1, OPHD_LOAD, MEM_RD, MEM_WR, SEQ_ERR};
                total++;
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL outputs at step %0d t=%0t: got xpt=%0d nxpt=%0d en=%b cm1=%b ophd=%b rd=%b wr=%b err=%b, want xpt=%0d nxpt=%0d en=%b cm1=%b ophd=%b rd=%b wr=%b err=%b",
                             ncyc, $time, act_v[15:11], act_v[10:6], act_v[5], act_v[4], act_v[3],
                             act_v[2], act_v[1], act_v[0], exp_v[15:11], exp_v[10:6], exp_v[5],
                             exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
                end
            end
        end
    end

    task automatic cycle(input bit rstn, input stim_t s);
        @(negedge CLK);
        notRESET     = rstn;
        PR_Reset_XPT = s.prx; P2_Set_CM1 = s.p2; Pa_Ophd = s.pa;
        PC_R0 = s.r0; PC_R1 = s.r1; PC_R2 = s.r2;
        PC_W0 = s.w0; PC_W1 = s.w1; PC_W2 = s.w2;
        MEM_WAIT = s.wt;
        if (rstn) model_step(s);
        else      model_reset();
        expq.push_back(model_vec());
    endtask

    // Reset asserted between edges with current strobes still held.
    task automatic async_reset();
        @(negedge CLK);
        #2;
        notRESET = 1'b0;
        model_reset();
        expq.push_back(model_vec());
        -> mon_ev;
        #2;
        expq.push_back(model_vec());
    endtask

    task automatic do_reset();
        stim_t idle;
        idle = '0;
        async_reset();
        cycle(1'b0, idle);
        cycle(1'b1, idle);
    endtask

    function automatic stim_t gen_legal();
        stim_t s;
        int unsigned k;
        s     = '0;
        s.prx = ($urandom_range(0, 11) == 0);
        s.p2  = ($urandom_range(0, 9) == 0);
        s.pa  = ($urandom_range(0, 5) == 0);
        s.wt  = $urandom_range(0, 1);
        k     = $urandom_range(0, 5);
        case (m_bus)
            0: begin s.r0 = (k == 0); s.w0 = (k == 1); end
            1: begin s.r1 = (k <= 2); s.r2 = (k == 3) || (k == 2 && s.wt == 0); end
            default: begin s.w1 = (k <= 2); s.w2 = (k == 3) || (k == 2 && s.wt == 0); end
        endcase
        return s;
    endfunction

    function automatic stim_t gen_chaos();
        stim_t s;
        s = '0;
        s.prx = ($urandom_range(0, 7) == 0);
        s.p2  = ($urandom_range(0, 7) == 0);
        s.pa  = ($urandom_range(0, 3) == 0);
        s.r0  = ($urandom_range(0, 9) == 0);
        s.r1  = ($urandom_range(0, 9) == 0);
        s.r2  = ($urandom_range(0, 9) == 0);
        s.w0  = ($urandom_range(0, 9) == 0);
        s.w1  = ($urandom_range(0, 9) == 0);
        s.w2  = ($urandom_range(0, 9) == 0);
        s.wt  = $urandom_range(0, 1);
        return s;
    endfunction

    initial begin
        stim_t idle, s;
        idle = '0;
        notRESET = 1'b0;
        PR_Reset_XPT = 0; P2_Set_CM1 = 0; Pa_Ophd = 0;
        PC_R0 = 0; PC_R1 = 0; PC_R2 = 0; PC_W0 = 0; PC_W1 = 0; PC_W2 = 0; MEM_WAIT = 0;
        model_reset();

        // Reset release and first M1 fetch, then read with two wait states.
        do_reset();
        repeat (4) cycle(1'b1, idle);
        s = idle; s.r0 = 1; cycle(1'b1, s);
        s = idle; s.r1 = 1; s.wt = 1; cycle(1'b1, s); cycle(1'b1, s);
        s = idle; s.r1 = 1; cycle(1'b1, s);
        s = idle; s.r2 = 1; cycle(1'b1, s);
        cycle(1'b1, idle);

        // Instruction end at XPT=18 with header latch.
        for (int i = 0; i < 40 && m_xpt != 18; i++) cycle(1'b1, idle);
        s = idle; s.prx = 1; s.p2 = 1; s.pa = 1; cycle(1'b1, s);
        repeat (5) cycle(1'b1, idle);

        // Saturation at 31 with sticky error.
        repeat (40) cycle(1'b1, idle);
        s = idle; s.prx = 1; cycle(1'b1, s);
        repeat (3) cycle(1'b1, idle);

        // Protocol errors: orphan read phase, then simultaneous read/write starts.
        do_reset();
        s = idle; s.r1 = 1; cycle(1'b1, s);
        repeat (2) cycle(1'b1, idle);
        do_reset();
        s = idle; s.r0 = 1; s.w0 = 1; cycle(1'b1, s);
        repeat (2) cycle(1'b1, idle);

        // Write cycle, legal R0->R2 read, then async reset mid-stall.
        do_reset();
        s = idle; s.w0 = 1; cycle(1'b1, s);
        s = idle; s.w1 = 1; s.wt = 1; cycle(1'b1, s);
        s = idle; s.w2 = 1; cycle(1'b1, s);
        s = idle; s.r0 = 1; cycle(1'b1, s);
        s = idle; s.r2 = 1; cycle(1'b1, s);
        s = idle; s.r0 = 1; cycle(1'b1, s);
        s = idle; s.r1 = 1; s.wt = 1; cycle(1'b1, s); cycle(1'b1, s);
        async_reset();
        cycle(1'b0, idle);
        cycle(1'b1, idle);
        repeat (3) cycle(1'b1, idle);

        // Randomized segments, mostly protocol-legal, every third one unconstrained.
        for (int seg = 0; seg < 15; seg++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                s = (seg % 3 == 2) ? gen_chaos() : gen_legal();
                cycle(1'b1, s);
            end
        end

        repeat (2) @(posedge CLK);
        #3;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard drain: got %0d pending, want 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
